// File: rtl/traffic_timer.sv
// ----------------------------------------------------------------------------
// traffic_timer
//
// Seconds timebase for the four-way traffic light controller. A prescaler
// divides clk into one-second ticks. A saturating counter then accumulates
// the whole seconds elapsed since the last restart. Two registered level
// flags tell the controller when the yellow (short) and green (long) phases
// have run their course.
//
// Parameters:
//   TICKS_PER_SEC  clk cycles per second (>= 1)
//   SHORT_SEC      seconds until one_sec_timer asserts (>= 1)
//   LONG_SEC       seconds until five_sec_timer asserts
//                  (SHORT_SEC <= LONG_SEC <= 2**SEC_W - 1)
//   SEC_W          width of the elapsed-seconds counter (>= 1)
//
// Ports:
//   clk             in   system clock, rising-edge active
//   reset           in   synchronous active-high reset
//   rst_count       in   restart request from the controller (level sampled)
//   hold            in   freeze the timebase (TRAFFIC_TIMER_HOLD_EN only)
//   one_sec_timer   out  high while elapsed_sec >= SHORT_SEC (registered)
//   five_sec_timer  out  high while elapsed_sec >= LONG_SEC (registered)
//   elapsed_sec     out  whole seconds since restart, saturating (registered)
//
// Build option:
//   TRAFFIC_TIMER_HOLD_EN  when defined, adds the hold port. While hold is
//                          high, all timer state is frozen. reset and
//                          rst_count still override it.
// ----------------------------------------------------------------------------
module traffic_timer #(
    parameter int TICKS_PER_SEC = 50_000_000,
    parameter int SHORT_SEC     = 1,
    parameter int LONG_SEC      = 5,
    parameter int SEC_W         = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             rst_count,
`ifdef TRAFFIC_TIMER_HOLD_EN
    input  logic             hold,
`endif
    output logic             one_sec_timer,
    output logic             five_sec_timer,
    output logic [SEC_W-1:0] elapsed_sec
);

    // The prescaler is just wide enough to hold TICKS_PER_SEC-1. A divide
    // ratio of 1 still needs a one-bit register; that register simply
    // never leaves 0.
    localparam int PRE_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;

    localparam logic [PRE_W-1:0] PRE_LAST  = PRE_W'(TICKS_PER_SEC - 1);
    localparam logic [SEC_W-1:0] SEC_MAX   = '1;
    localparam logic [SEC_W-1:0] SHORT_THR = SEC_W'(SHORT_SEC);
    localparam logic [SEC_W-1:0] LONG_THR  = SEC_W'(LONG_SEC);

    // Elaboration-time sanity checks. A bad combination would otherwise
    // yield thresholds that never match, or a flag that can never rise.
    if (TICKS_PER_SEC < 1) begin : g_bad_ticks
        $error("traffic_timer: TICKS_PER_SEC must be >= 1");
    end
    if (SEC_W < 1) begin : g_bad_width
        $error("traffic_timer: SEC_W must be >= 1");
    end
    if (SHORT_SEC < 1) begin : g_bad_short
        $error("traffic_timer: SHORT_SEC must be >= 1");
    end
    if (LONG_SEC < SHORT_SEC) begin : g_bad_order
        $error("traffic_timer: LONG_SEC must be >= SHORT_SEC");
    end
    if (longint'(LONG_SEC) > ((longint'(1) << SEC_W) - 1)) begin : g_bad_long
        $error("traffic_timer: LONG_SEC does not fit in SEC_W bits");
    end

    logic [PRE_W-1:0] pre_cnt;
    logic [PRE_W-1:0] pre_next;
    logic [SEC_W-1:0] sec_next;
    logic             sec_tick;
    logic             frozen;

    // In a hold-capable build, frozen follows the hold pin. Otherwise it is
    // tied low, so the rest of the logic is identical in both builds.
`ifdef TRAFFIC_TIMER_HOLD_EN
    assign frozen = hold;
`else
    assign frozen = 1'b0;
`endif

    // Next-state arithmetic for normal counting.
    //
    // sec_tick marks the last prescaler cycle of each second. On that
    // cycle the prescaler wraps and the seconds counter advances. Once the
    // counter reaches all-ones it stays there, so a controller that stalls
    // for a long time sees saturated flags rather than a wrapped count.
    always_comb begin
        sec_tick = (pre_cnt == PRE_LAST);
        pre_next = sec_tick ? '0 : pre_cnt + PRE_W'(1);
        sec_next = elapsed_sec;
        if (sec_tick && (elapsed_sec != SEC_MAX)) begin
            sec_next = elapsed_sec + SEC_W'(1);
        end
    end

    // State registers.
    //
    // Priority: reset, then restart, then hold, then count.
    //
    // A restart clears everything, even when it lands on a tick cycle.
    // Because the flags are cleared in the same edge, the controller never
    // sees a stale flag in the state it just entered.
    //
    // The flags are computed from sec_next rather than from the current
    // count. This keeps them in step with elapsed_sec every cycle, instead
    // of lagging it by one.
    always_ff @(posedge clk) begin
        if (reset) begin
            pre_cnt        <= '0;
            elapsed_sec    <= '0;
            one_sec_timer  <= 1'b0;
            five_sec_timer <= 1'b0;
        end else if (rst_count) begin
            pre_cnt        <= '0;
            elapsed_sec    <= '0;
            one_sec_timer  <= 1'b0;
            five_sec_timer <= 1'b0;
        end else if (!frozen) begin
            pre_cnt        <= pre_next;
            elapsed_sec    <= sec_next;
            one_sec_timer  <= (sec_next >= SHORT_THR);
            five_sec_timer <= (sec_next >= LONG_THR);
        end
    end

endmodule
